alu: RTL and testbench

//  32-bit integer ALU for the single-cycle/multi-cycle CPU datapath (execute stage).

---
 rtl/alu.sv | 94 +++++++++
 tb/tb_alu.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered 32-bit execute-stage ALU: logic, add/sub, signed set-less-than, logical shifts.
// Optional build macro ALU_OVERFLOW_EN adds a registered signed-overflow flag output.
module alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   sl,
  input  logic [2:0]       ALUctr,
  output logic [WIDTH-1:0] Result,
  output logic             zero
`ifdef ALU_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SLL = 3'b011,
    OP_XOR = 3'b100,
    OP_SRL = 3'b101,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } alu_op_e;

  alu_op_e          op;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             slt;
  logic [WIDTH-1:0] result_d, result_q;
  logic             zero_d, zero_q;

  assign op   = alu_op_e'(ALUctr);
  assign sum  = A + B;
  assign diff = A - B;
  assign slt  = $signed(A) < $signed(B);

  always_comb begin
    result_d = '0;
    case (op)
      OP_AND:  result_d = A & B;
      OP_OR:   result_d = A | B;
      OP_ADD:  result_d = sum;
      OP_SLL:  result_d = B << sl;
      OP_XOR:  result_d = A ^ B;
      OP_SRL:  result_d = B >> sl;
      OP_SUB:  result_d = diff;
      OP_SLT:  result_d = WIDTH'(slt);
      default: result_d = '0;
    endcase
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign Result = result_q;
  assign zero   = zero_q;

`ifdef ALU_OVERFLOW_EN
  logic ovf_d, ovf_q;

  // Signed overflow: operands' signs (B inverted for SUB) agree but the result's sign does not.
  always_comb begin
    ovf_d = 1'b0;
    case (op)
      OP_ADD:  ovf_d = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      OP_SUB:  ovf_d = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      default: ovf_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: expectations queued at drive time, popped one cycle later.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] A = '0, B = '0;
  logic [4:0]  sl = '0;
  logic [2:0]  ALUctr = '0;
  logic [31:0] Result;
  logic        zero;
`ifdef ALU_OVERFLOW_EN
  logic        overflow;
`endif

  always #5 clk = ~clk;

  alu #(.WIDTH(32), .SHW(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .sl       (sl),
    .ALUctr   (ALUctr),
    .Result   (Result),
    .zero     (zero)
`ifdef ALU_OVERFLOW_EN
    ,
    .overflow (overflow)
`endif
  );

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        z;
    logic        ov;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  logic in_valid = 1'b0;
  logic exp_due  = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model written independently of the RTL: shifts by repeated single-bit steps,
  // subtraction as two's complement addition, signed compare by sign cases.
  function automatic exp_t model(input string tag, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b, input logic [4:0] s);
    exp_t        e;
    logic [32:0] wide;
    logic [31:0] r;
    logic        ov;
    r  = '0;
    ov = 1'b0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: begin
        wide = {1'b0, a} + {1'b0, b};
        r    = wide[31:0];
        ov   = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'b011: begin
        r = b;
        for (int i = 0; i < int'(s); i++) r = {r[30:0], 1'b0};
      end
      3'b100: r = a ^ b;
      3'b101: begin
        r = b;
        for (int i = 0; i < int'(s); i++) r = {1'b0, r[31:1]};
      end
      3'b110: begin
        r  = a + ~b + 32'd1;
        ov = (a[31] != b[31]) && (r[31] != a[31]);
      end
      default: begin
        if (a[31] && !b[31])                r = 32'd1;
        else if (a[31] == b[31] && a < b)   r = 32'd1;
        else                                r = 32'd0;
      end
    endcase
    e.tag = tag;
    e.res = r;
    e.z   = (r == 32'd0);
    e.ov  = ov;
    return e;
  endfunction

  task automatic drive_exp(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] s,
                           input logic [31:0] r, input logic z, input logic ov);
    exp_t e;
    @(negedge clk);
    rst      = 1'b0;
    ALUctr   = op;
    A        = a;
    B        = b;
    sl       = s;
    in_valid = 1'b1;
    e.tag = tag;
    e.res = r;
    e.z   = z;
    e.ov  = ov;
    sb.push_back(e);
  endtask

  task automatic drive(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] s);
    exp_t e;
    e = model(tag, op, a, b, s);
    drive_exp(tag, op, a, b, s, e.res, e.z, e.ov);
  endtask

  task automatic do_reset(input string tag);
    exp_t e;
    @(negedge clk);
    rst      = 1'b1;
    A        = $urandom;
    B        = $urandom;
    sl       = 5'($urandom);
    ALUctr   = 3'($urandom);
    in_valid = 1'b1;
    e.tag = tag;
    e.res = '0;
    e.z   = 1'b1;
    e.ov  = 1'b0;
    sb.push_back(e);
  endtask

  always @(posedge clk) exp_due <= in_valid;

  always @(negedge clk) begin
    exp_t e;
    if (exp_due) begin
      if (sb.size() == 0) begin
        check_val("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_val({e.tag, ".res"}, Result, e.res);
        check_val({e.tag, ".zero"}, 32'(zero), 32'(e.z));
`ifdef ALU_OVERFLOW_EN
        check_val({e.tag, ".ovf"}, 32'(overflow), 32'(e.ov));
`endif
      end
    end
  end

  initial begin
    do_reset("reset");
    drive_exp("add_5_7", 3'b010, 32'd5, 32'd7, 5'd0, 32'd12, 1'b0, 1'b0);

    for (int unsigned i = 0; i < 16; i++)
      drive("add_wrap_step", 3'b010, 32'hFFFF_FFF0 + i, 32'd1, 5'd0);
    drive_exp("add_wrap", 3'b010, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 1'b1, 1'b0);
    drive_exp("sub_wrap", 3'b110, 32'd0, 32'd1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);

    drive_exp("and", 3'b000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, 32'h00F0_000F, 1'b0, 1'b0);
    drive_exp("or",  3'b001, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, 32'hFFF0_0FFF, 1'b0, 1'b0);
    drive_exp("xor", 3'b100, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, 32'hFF00_0FF0, 1'b0, 1'b0);

    drive_exp("sll31", 3'b011, 32'hDEAD_BEEF, 32'd1, 5'd31, 32'h8000_0000, 1'b0, 1'b0);
    drive_exp("srl31", 3'b101, 32'h1234_5678, 32'h8000_0000, 5'd31, 32'd1, 1'b0, 1'b0);
    drive_exp("sll0", 3'b011, 32'hFFFF_FFFF, 32'hA5A5_1234, 5'd0, 32'hA5A5_1234, 1'b0, 1'b0);
    drive_exp("srl0", 3'b101, 32'h0, 32'h8765_4321, 5'd0, 32'h8765_4321, 1'b0, 1'b0);
    drive_exp("sll4", 3'b011, 32'h0, 32'hF000_000F, 5'd4, 32'h0000_00F0, 1'b0, 1'b0);
    drive_exp("srl4", 3'b101, 32'h0, 32'hF000_000F, 5'd4, 32'h0F00_0000, 1'b0, 1'b0);

    drive_exp("sub_eq", 3'b110, 32'd3, 32'd3, 5'd0, 32'd0, 1'b1, 1'b0);
    drive_exp("slt_neg", 3'b111, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1, 1'b0, 1'b0);
    drive_exp("slt_pos", 3'b111, 32'd1, 32'hFFFF_FFFF, 5'd0, 32'd0, 1'b1, 1'b0);
    drive_exp("slt_min", 3'b111, 32'h8000_0000, 32'd0, 5'd0, 32'd1, 1'b0, 1'b0);
    drive_exp("slt_eq", 3'b111, 32'h1234_5678, 32'h1234_5678, 5'd0, 32'd0, 1'b1, 1'b0);

    drive_exp("add_ovf", 3'b010, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000, 1'b0, 1'b1);
    drive_exp("sub_ovf", 3'b110, 32'h8000_0000, 32'd1, 5'd0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    do_reset("reset_mid");
    drive_exp("add_neg_ovf", 3'b010, 32'h8000_0000, 32'h8000_0000, 5'd0, 32'd0, 1'b1, 1'b1);
    drive_exp("sub_no_ovf", 3'b110, 32'h8000_0000, 32'h8000_0000, 5'd0, 32'd0, 1'b1, 1'b0);

    for (int unsigned i = 0; i < 60; i++)
      drive("rand", 3'(i % 8), $urandom, $urandom, 5'($urandom));

    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_val("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
